// File: rtl/router_input_unit_if.sv
// Link bundle for one router input port: upstream flit handshake,
// crossbar path request/grant and the flit stream towards the crossbar.
interface router_input_unit_if #(
  parameter int FLIT_SIZE = 19
);
  logic [FLIT_SIZE-1:0] in_flit;
  logic                 in_valid;
  logic                 in_ready;
  logic                 route_req;
  logic [2:0]           route_port;
  logic                 route_grant;
  logic [FLIT_SIZE-1:0] out_flit;
  logic                 out_valid;
  logic                 out_ready;

  // master is the environment (upstream link, arbiter, crossbar); slave is the input unit
  modport master (
    output in_flit, in_valid, route_grant, out_ready,
    input  in_ready, route_req, route_port, out_flit, out_valid
  );

  modport slave (
    input  in_flit, in_valid, route_grant, out_ready,
    output in_ready, route_req, route_port, out_flit, out_valid
  );
endinterface

// File: rtl/router_input_unit.sv
// Per-port NoC router input unit: flit FIFO, XY route computation and the
// crossbar request FSM that forwards one packet (HEAD..TAIL) at a time.
module router_input_unit #(
  parameter int FLIT_SIZE = 19,
  parameter int ADDR_BITS = 8,
  parameter int DEPTH     = 8,
  parameter int CNT_BITS  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_BITS-1:0]   cfg_xaddr,
  input  logic [ADDR_BITS-1:0]   cfg_yaddr,
  router_input_unit_if.slave     link,
  output logic [1:0]             buf_status,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [CNT_BITS-1:0]    drop_cnt
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  localparam logic [1:0] T_HEAD = 2'd0;
  localparam logic [1:0] T_TAIL = 2'd1;

  localparam logic [2:0] P_LOCAL = 3'd0;
  localparam logic [2:0] P_NORTH = 3'd1;
  localparam logic [2:0] P_SOUTH = 3'd2;
  localparam logic [2:0] P_EAST  = 3'd3;
  localparam logic [2:0] P_WEST  = 3'd4;
  localparam logic [2:0] P_NONE  = 3'd5;

  localparam logic [1:0] ST_SENT     = 2'd0;
  localparam logic [1:0] ST_RECEIVED = 2'd1;
  localparam logic [1:0] ST_FILLING  = 2'd2;
  localparam logic [1:0] ST_EMPTY    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUTING,
    S_WAITING,
    S_ACTIVE
  } state_t;

  logic [FLIT_SIZE-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]     count_q, count_d;
  logic [OCC_W-1:0]     tail_cnt_q, tail_cnt_d;
  state_t               state_q, state_d;
  logic [2:0]           route_port_q, route_port_d;
  logic [1:0]           status_q, status_d;
  logic [CNT_BITS-1:0]  drop_q, drop_d;

  logic                 empty, full;
  logic                 push, pop, fwd_pop, drop_pop;
  logic                 tail_in, tail_out, tail_sent;
  logic [FLIT_SIZE-1:0] front;
  logic [1:0]           front_type;
  logic [ADDR_BITS-1:0] dest_x, dest_y;
  logic [2:0]           xy_port;

  assign empty      = (count_q == '0);
  assign full       = (count_q == OCC_W'(DEPTH));
  assign front      = mem_q[rd_ptr_q];
  assign front_type = front[FLIT_SIZE-2 -: 2];
  assign dest_x     = front[2*ADDR_BITS-1:ADDR_BITS];
  assign dest_y     = front[ADDR_BITS-1:0];

  // Flits whose valid bit is clear are consumed from the link but never stored.
  assign push = link.in_valid && !full && link.in_flit[FLIT_SIZE-1];
  assign pop  = fwd_pop || drop_pop;

  assign tail_in   = push && (link.in_flit[FLIT_SIZE-2 -: 2] == T_TAIL);
  assign tail_out  = pop && (front_type == T_TAIL);
  assign tail_sent = fwd_pop && (front_type == T_TAIL);

  // X is resolved before Y; coordinates are unsigned.
  always_comb begin
    xy_port = P_LOCAL;
    if (dest_x > cfg_xaddr) begin
      xy_port = P_EAST;
    end else if (dest_x < cfg_xaddr) begin
      xy_port = P_WEST;
    end else if (dest_y > cfg_yaddr) begin
      xy_port = P_SOUTH;
    end else if (dest_y < cfg_yaddr) begin
      xy_port = P_NORTH;
    end
  end

  always_comb begin
    state_d        = state_q;
    route_port_d   = route_port_q;
    drop_pop       = 1'b0;
    fwd_pop        = 1'b0;
    link.route_req = 1'b0;
    link.out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          if (front_type == T_HEAD) begin
            state_d      = S_ROUTING;
            route_port_d = xy_port;
          end else begin
            drop_pop = 1'b1;
          end
        end
      end
      S_ROUTING: begin
        link.route_req = 1'b1;
        state_d        = link.route_grant ? S_ACTIVE : S_WAITING;
      end
      S_WAITING: begin
        link.route_req = 1'b1;
        if (link.route_grant) begin
          state_d = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        // The path stays requested until the TAIL leaves; a stray HEAD is just data here.
        link.route_req = 1'b1;
        link.out_valid = !empty;
        fwd_pop        = !empty && link.out_ready;
        if (fwd_pop && (front_type == T_TAIL)) begin
          state_d      = S_IDLE;
          route_port_d = P_NONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    count_d    = count_q + OCC_W'(push) - OCC_W'(pop);
    tail_cnt_d = tail_cnt_q + OCC_W'(tail_in) - OCC_W'(tail_out);
    drop_d     = drop_q;
    if (drop_pop && (drop_q != '1)) begin
      drop_d = drop_q + CNT_BITS'(1);
    end
    // Status reflects the buffer as it will be after this edge.
    if (tail_sent) begin
      status_d = ST_SENT;
    end else if (count_d == '0) begin
      status_d = ST_EMPTY;
    end else if (tail_cnt_d != '0) begin
      status_d = ST_RECEIVED;
    end else begin
      status_d = ST_FILLING;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= link.in_flit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      tail_cnt_q   <= '0;
      state_q      <= S_IDLE;
      route_port_q <= P_NONE;
      status_q     <= ST_EMPTY;
      drop_q       <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      tail_cnt_q   <= tail_cnt_d;
      state_q      <= state_d;
      route_port_q <= route_port_d;
      status_q     <= status_d;
      drop_q       <= drop_d;
    end
  end

  assign link.in_ready   = !full;
  assign link.out_flit   = empty ? '0 : front;
  assign link.route_port = route_port_q;
  assign buf_status      = status_q;
  assign occupancy       = count_q;
  assign drop_cnt        = drop_q;
endmodule
